// File: rtl/audio_pwm_sink_pkg.sv
// rtl/audio_pwm_sink_pkg.sv - shared audio channel widths, defaults and helpers
package audio_pwm_sink_pkg;

    localparam int SAMPLE_W  = 8;
    localparam int CARRIER_W = 8;

    localparam logic [SAMPLE_W-1:0]  IDLE_DUTY_DEFAULT = 8'h80;
    localparam logic [CARRIER_W-1:0] CARRIER_MAX       = '1;

    typedef logic [SAMPLE_W-1:0] sample_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/audio_pwm_sink_sync_fifo.sv
// rtl/audio_pwm_sink_sync_fifo.sv - single-clock FIFO with fall-through head and level count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;

    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));
    assign dout  = mem[rd_ptr];

    // A pop on empty is ignored; a pop on full frees the slot the push takes.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/audio_pwm_sink.sv
// rtl/audio_pwm_sink.sv - buffered 8-bit PWM audio output with frame-synchronous sample updates
module audio_pwm_sink
    import audio_pwm_sink_pkg::*;
#(
    parameter int                  FIFO_DEPTH = 8,
    parameter logic [SAMPLE_W-1:0] IDLE_DUTY  = IDLE_DUTY_DEFAULT
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_enable,
    input  logic                          i_sample_valid,
    input  logic [SAMPLE_W-1:0]           i_sample,
    output logic                          o_pwm,
    output logic [SAMPLE_W-1:0]           o_duty,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_underrun,
    output logic [7:0]                    o_overflow_count
);

    logic [CARRIER_W-1:0] cnt;
    sample_t              duty;
    sample_t              head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 frame_end;
    logic                 pop_taken;
    logic                 drop;

    assign frame_end = i_enable && (cnt == CARRIER_MAX);
    assign pop_taken = frame_end && !fifo_empty;
    assign drop      = i_sample_valid && fifo_full && !pop_taken;
    assign o_duty    = duty;

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (i_sample_valid),
        .pop   (frame_end),
        .din   (i_sample),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (o_fifo_level)
    );

    // The last carrier slot (cnt=255) is never high, so the duty swap there is glitch-free.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt              <= '0;
            duty             <= IDLE_DUTY;
            o_pwm            <= 1'b0;
            o_underrun       <= 1'b0;
            o_overflow_count <= 8'd0;
        end else begin
            cnt        <= i_enable ? cnt + CARRIER_W'(1) : '0;
            o_pwm      <= i_enable && (cnt < duty);
            o_underrun <= frame_end && fifo_empty;
            if (pop_taken) duty <= head;
            if (drop) o_overflow_count <= sat_inc8(o_overflow_count);
        end
    end

endmodule
